// File: rtl/wb_stage_pkg.sv
// rtl/wb_stage_pkg.sv - shared encodings, widths and the WB register layout for wb_stage
package wb_stage_pkg;

  localparam int DW = 32;
  localparam int AW = 5;

  typedef enum logic [2:0] {
    LD_W  = 3'd0,
    LD_B  = 3'd1,
    LD_BU = 3'd2,
    LD_H  = 3'd3,
    LD_HU = 3'd4
  } ld_type_e;

  typedef enum logic [1:0] {
    WS_ALU  = 2'd0,
    WS_MEM  = 2'd1,
    WS_LINK = 2'd2
  } wsel_e;

  typedef struct packed {
    logic          valid;
    logic          regwrite;
    logic [AW-1:0] a3;
    logic [1:0]    wsel;
    logic [2:0]    ld_type;
    logic [1:0]    byte_off;
    logic [DW-1:0] alu_res;
    logic [DW-1:0] mem_rd;
    logic [DW-1:0] pc8;
  } wb_regs_t;

endpackage

// File: rtl/wb_stage_load_ext.sv
// rtl/wb_stage_load_ext.sv - combinational byte/halfword extract and sign/zero extend of a loaded word
// Little-endian lanes; halfword lane picked by byte_off[1] alone, unknown load types pass the word through.
module load_ext
  import wb_stage_pkg::*;
(
  input  logic [2:0]    i_ld_type,
  input  logic [1:0]    i_byte_off,
  input  logic [DW-1:0] i_mem_rd,
  output logic [DW-1:0] o_ld_data
);

  logic [7:0]  w_byte;
  logic [15:0] w_half;

  assign w_byte = i_mem_rd[8*i_byte_off +: 8];
  assign w_half = i_byte_off[1] ? i_mem_rd[31:16] : i_mem_rd[15:0];

  always_comb begin
    o_ld_data = i_mem_rd;
    case (i_ld_type)
      LD_B:    o_ld_data = {{24{w_byte[7]}}, w_byte};
      LD_BU:   o_ld_data = {24'd0, w_byte};
      LD_H:    o_ld_data = {{16{w_half[15]}}, w_half};
      LD_HU:   o_ld_data = {16'd0, w_half};
      default: o_ld_data = i_mem_rd;
    endcase
  end

endmodule

// File: rtl/wb_stage.sv
// rtl/wb_stage.sv - MEM/WB pipeline register and writeback data select driving the GPR write port
// Optional retire counter output W_RetireCnt is built when WB_RETIRE_CNT_EN is defined.
module wb_stage #(
  parameter int DW = 32,
  parameter int AW = 5
) (
  input  logic          Clk,
  input  logic          Rst,
  input  logic          Stall,
  input  logic          Flush,
  input  logic          M_Valid,
  input  logic          M_RegWrite,
  input  logic [AW-1:0] M_A3,
  input  logic [1:0]    M_WSel,
  input  logic [2:0]    M_LdType,
  input  logic [1:0]    M_ByteOff,
  input  logic [DW-1:0] M_ALURes,
  input  logic [DW-1:0] M_MemRD,
  input  logic [DW-1:0] M_PC8,
  output logic          W_Valid,
  output logic          W_We,
  output logic [AW-1:0] W_A3,
  output logic [DW-1:0] W_WD
`ifdef WB_RETIRE_CNT_EN
  ,
  output logic [31:0]   W_RetireCnt
`endif
);

  import wb_stage_pkg::*;

  wb_regs_t r_wb;
  logic [DW-1:0] w_ld_data;

  always_ff @(posedge Clk) begin
    if (!Rst) begin
      r_wb <= '0;
    end else if (Flush) begin
      r_wb <= '0;
    end else if (!Stall) begin
      r_wb.valid    <= M_Valid;
      r_wb.regwrite <= M_RegWrite;
      r_wb.a3       <= M_A3;
      r_wb.wsel     <= M_WSel;
      r_wb.ld_type  <= M_LdType;
      r_wb.byte_off <= M_ByteOff;
      r_wb.alu_res  <= M_ALURes;
      r_wb.mem_rd   <= M_MemRD;
      r_wb.pc8      <= M_PC8;
    end
  end

  load_ext u_load_ext (
    .i_ld_type (r_wb.ld_type),
    .i_byte_off(r_wb.byte_off),
    .i_mem_rd  (r_wb.mem_rd),
    .o_ld_data (w_ld_data)
  );

  // The regfile bypass depends on We never being raised for $0.
  assign W_Valid = r_wb.valid;
  assign W_We    = r_wb.valid & r_wb.regwrite & (r_wb.a3 != '0);
  assign W_A3    = r_wb.a3;

  always_comb begin
    W_WD = r_wb.alu_res;
    case (r_wb.wsel)
      WS_MEM:  W_WD = w_ld_data;
      WS_LINK: W_WD = r_wb.pc8;
      default: W_WD = r_wb.alu_res;
    endcase
  end

`ifdef WB_RETIRE_CNT_EN
  logic [31:0] r_retire_cnt;

  // An instruction retires when it leaves WB; a flush still lets the current one go.
  always_ff @(posedge Clk) begin
    if (!Rst) begin
      r_retire_cnt <= '0;
    end else if (r_wb.valid && !Stall) begin
      r_retire_cnt <= r_retire_cnt + 32'd1;
    end
  end

  assign W_RetireCnt = r_retire_cnt;
`endif

endmodule

// File: tb/tb_wb_stage.sv
// tb/tb_wb_stage.sv - scoreboard bench for wb_stage (define WB_RETIRE_CNT_EN to cover the retire counter)
module tb_wb_stage;

  typedef struct packed {
    logic        v;
    logic        we;
    logic [4:0]  a3;
    logic [31:0] wd;
    logic [31:0] cnt;
  } exp_t;

  logic        Clk = 1'b0;
  logic        Rst, Stall, Flush, M_Valid, M_RegWrite;
  logic [4:0]  M_A3;
  logic [1:0]  M_WSel, M_ByteOff;
  logic [2:0]  M_LdType;
  logic [31:0] M_ALURes, M_MemRD, M_PC8;
  logic        W_Valid, W_We;
  logic [4:0]  W_A3;
  logic [31:0] W_WD;
`ifdef WB_RETIRE_CNT_EN
  logic [31:0] W_RetireCnt;
`endif

  int   total = 0;
  int   bad   = 0;
  exp_t sb[$];
  exp_t m = '0;

  always #5 Clk = ~Clk;

  wb_stage #(.DW(32), .AW(5)) dut (
    .Clk       (Clk),
    .Rst       (Rst),
    .Stall     (Stall),
    .Flush     (Flush),
    .M_Valid   (M_Valid),
    .M_RegWrite(M_RegWrite),
    .M_A3      (M_A3),
    .M_WSel    (M_WSel),
    .M_LdType  (M_LdType),
    .M_ByteOff (M_ByteOff),
    .M_ALURes  (M_ALURes),
    .M_MemRD   (M_MemRD),
    .M_PC8     (M_PC8),
    .W_Valid   (W_Valid),
    .W_We      (W_We),
    .W_A3      (W_A3),
    .W_WD      (W_WD)
`ifdef WB_RETIRE_CNT_EN
    ,
    .W_RetireCnt(W_RetireCnt)
`endif
  );

  task automatic check(input string tag, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s got=%h want=%h", tag, act, exp);
    end
  endtask

  function automatic logic [31:0] ref_wd(input logic [1:0] ws, input logic [2:0] lt,
                                         input logic [1:0] off, input logic [31:0] alu,
                                         input logic [31:0] rd, input logic [31:0] pc8);
    logic [31:0] sh;
    if (ws == 2'd2) return pc8;
    if (ws != 2'd1) return alu;
    case (lt)
      3'd1: begin sh = rd >> (off * 8); return {{24{sh[7]}}, sh[7:0]}; end
      3'd2: begin sh = rd >> (off * 8); return {24'h0, sh[7:0]}; end
      3'd3: begin sh = off[1] ? (rd >> 16) : rd; return {{16{sh[15]}}, sh[15:0]}; end
      3'd4: begin sh = off[1] ? (rd >> 16) : rd; return {16'h0, sh[15:0]}; end
      default: return rd;
    endcase
  endfunction

  task automatic drv(input logic v, input logic rw, input logic [4:0] a3, input logic [1:0] ws,
                     input logic [2:0] lt, input logic [1:0] off, input logic [31:0] alu,
                     input logic [31:0] rd, input logic [31:0] pc8);
    M_Valid = v; M_RegWrite = rw; M_A3 = a3; M_WSel = ws; M_LdType = lt;
    M_ByteOff = off; M_ALURes = alu; M_MemRD = rd; M_PC8 = pc8;
  endtask

  // Predict the post-edge outputs from the current inputs, then advance one clock and compare.
  task automatic cyc();
    exp_t n, e;
    logic [31:0] c;
    c = !Rst ? 32'd0 : ((m.v && !Stall) ? m.cnt + 32'd1 : m.cnt);
    if (!Rst || Flush) n = '0;
    else if (Stall) n = m;
    else begin
      n.v  = M_Valid;
      n.a3 = M_A3;
      n.we = M_Valid && M_RegWrite && (M_A3 != 5'd0);
      n.wd = ref_wd(M_WSel, M_LdType, M_ByteOff, M_ALURes, M_MemRD, M_PC8);
    end
    n.cnt = c;
    m = n;
    sb.push_back(n);
    @(posedge Clk);
    #1;
    e = sb.pop_front();
    check("valid", {31'd0, W_Valid}, {31'd0, e.v});
    check("we", {31'd0, W_We}, {31'd0, e.we});
    check("a3", {27'd0, W_A3}, {27'd0, e.a3});
    check("wd", W_WD, e.wd);
`ifdef WB_RETIRE_CNT_EN
    check("retire_cnt", W_RetireCnt, e.cnt);
`endif
  endtask

  initial begin
    Rst = 1'b0; Stall = 1'b0; Flush = 1'b0;
    drv(1, 1, 5'd5, 2'd0, 3'd0, 2'd0, 32'hAAAA_5555, 32'h0, 32'h0);
    @(posedge Clk); #1;

    // Reset holds everything at zero despite a valid MEM instruction.
    cyc(); cyc();
    check("rst_we", {31'd0, W_We}, 32'd0);
    check("rst_wd", W_WD, 32'd0);
    Rst = 1'b1;
    cyc();
    check("post_rst_we", {31'd0, W_We}, 32'd1);
    check("post_rst_a3", {27'd0, W_A3}, 32'd5);

    // Load extraction vectors.
    drv(1, 1, 5'd3, 2'd1, 3'd1, 2'd0, 32'h0, 32'h8011_22F3, 32'h0); cyc();
    check("lb_off0", W_WD, 32'hFFFF_FFF3);
    drv(1, 1, 5'd3, 2'd1, 3'd1, 2'd3, 32'h0, 32'h8011_22F3, 32'h0); cyc();
    check("lb_off3", W_WD, 32'hFFFF_FF80);
    drv(1, 1, 5'd3, 2'd1, 3'd2, 2'd3, 32'h0, 32'h8011_22F3, 32'h0); cyc();
    check("lbu_off3", W_WD, 32'h0000_0080);
    drv(1, 1, 5'd3, 2'd1, 3'd3, 2'd2, 32'h0, 32'h8011_22F3, 32'h0); cyc();
    check("lh_off2", W_WD, 32'hFFFF_8011);
    drv(1, 1, 5'd3, 2'd1, 3'd4, 2'd1, 32'h0, 32'h8011_22F3, 32'h0); cyc();
    check("lhu_off1", W_WD, 32'h0000_22F3);
    drv(1, 1, 5'd3, 2'd1, 3'd6, 2'd2, 32'h0, 32'h8011_22F3, 32'h0); cyc();
    check("ld_type6", W_WD, 32'h8011_22F3);

    // Writes to $0 never raise We.
    drv(1, 1, 5'd0, 2'd0, 3'd0, 2'd0, 32'hDEAD_BEEF, 32'h0, 32'h0); cyc();
    check("r0_we", {31'd0, W_We}, 32'd0);
    check("r0_wd", W_WD, 32'hDEAD_BEEF);

    // JAL link write.
    drv(1, 1, 5'd31, 2'd2, 3'd0, 2'd0, 32'h1, 32'h2, 32'h0040_0010); cyc();
    check("jal_wd", W_WD, 32'h0040_0010);
    check("jal_a3", {27'd0, W_A3}, 32'd31);

    // Stall holds a valid write while MEM keeps changing; flush beats stall.
    drv(1, 1, 5'd7, 2'd0, 3'd0, 2'd0, 32'h1234, 32'h0, 32'h0); cyc();
    Stall = 1'b1;
    for (int i = 0; i < 3; i++) begin
      drv(1, 1, 5'(i + 10), 2'd1, 3'd1, 2'(i), $urandom, $urandom, $urandom);
      cyc();
      check("stall_a3", {27'd0, W_A3}, 32'd7);
      check("stall_wd", W_WD, 32'h1234);
      check("stall_we", {31'd0, W_We}, 32'd1);
    end
    Flush = 1'b1;
    cyc();
    check("flush_valid", {31'd0, W_Valid}, 32'd0);
    check("flush_we", {31'd0, W_We}, 32'd0);
    Flush = 1'b0; Stall = 1'b0;

`ifdef WB_RETIRE_CNT_EN
    begin
      logic [31:0] base;
      drv(0, 0, 5'd0, 2'd0, 3'd0, 2'd0, 32'h0, 32'h0, 32'h0); cyc();
      base = m.cnt;
      for (int i = 0; i < 10; i++) begin
        drv(1, 1, 5'(i + 1), 2'd0, 3'd0, 2'd0, 32'(i), 32'h0, 32'h0);
        if (i == 9) Flush = 1'b1;
        cyc();
        Flush = 1'b0;
        if (i == 3) begin
          Stall = 1'b1; cyc(); cyc(); Stall = 1'b0;
        end
      end
      drv(0, 0, 5'd0, 2'd0, 3'd0, 2'd0, 32'h0, 32'h0, 32'h0); cyc(); cyc();
      check("retire_nine", W_RetireCnt, base + 32'd9);

      force dut.r_retire_cnt = 32'hFFFF_FFFE;
      release dut.r_retire_cnt;
      m.cnt = 32'hFFFF_FFFE;
      drv(1, 1, 5'd4, 2'd0, 3'd0, 2'd0, 32'h5, 32'h0, 32'h0); cyc(); cyc(); cyc();
      check("retire_wrap", W_RetireCnt, 32'h0000_0000);
    end
`endif

    // Randomized traffic with occasional stall, flush and reset.
    for (int i = 0; i < 200; i++) begin
      Rst   = ($urandom_range(0, 19) != 0);
      Flush = ($urandom_range(0, 7) == 0);
      Stall = ($urandom_range(0, 4) == 0);
      drv(1'($urandom), 1'($urandom), 5'($urandom_range(0, 3) == 0 ? 0 : $urandom),
          2'($urandom), 3'($urandom), 2'($urandom), $urandom, $urandom, $urandom);
      cyc();
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
